// File: rtl/glyph_operator_matcher_pkg.sv
// Shared definitions for the operator glyph matcher: candidate table, glyph ROM layout, FSM states.
// The code->base table is the same one the operator glyph generator uses to fetch glyphs.
package glyph_operator_matcher_pkg;

   localparam int NUM_OPS = 10;
   localparam int ROWS = 8;
   localparam logic [7:0] FIRST_CODE = 8'd20;
   localparam logic [9:0] SPACE_ADDR = 10'o400;
   localparam logic [3:0] LAST_CAND = 4'(NUM_OPS - 1);
   localparam logic [3:0] LAST_ROW = 4'(ROWS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [9:0] op_base(input logic [3:0] idx);
      logic [9:0] base;
      case (idx)
         4'd0:    base = 10'o530;
         4'd1:    base = 10'o550;
         4'd2:    base = 10'o520;
         4'd3:    base = 10'o570;
         4'd4:    base = 10'o460;
         4'd5:    base = 10'o410;
         4'd6:    base = 10'o720;
         4'd7:    base = 10'o670;
         4'd8:    base = 10'o700;
         4'd9:    base = 10'o710;
         default: base = SPACE_ADDR;
      endcase
      return base;
   endfunction

   // ROM rows are MSB-first (bit 7 = column 0); the display bus is LSB-first.
   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/glyph_operator_matcher_if.sv
// Request/result bundle of the glyph matcher: start strobe, eight LSB-first glyph rows, status and result.
// The master drives the request, the slave (the matcher) drives status and result.
interface glyph_operator_matcher_if;
   logic       start;
   logic [7:0] glyph_row0;
   logic [7:0] glyph_row1;
   logic [7:0] glyph_row2;
   logic [7:0] glyph_row3;
   logic [7:0] glyph_row4;
   logic [7:0] glyph_row5;
   logic [7:0] glyph_row6;
   logic [7:0] glyph_row7;
   logic       busy;
   logic       done;
   logic       match_valid;
   logic [7:0] op_code;

   modport master (
      output start, glyph_row0, glyph_row1, glyph_row2, glyph_row3,
             glyph_row4, glyph_row5, glyph_row6, glyph_row7,
      input  busy, done, match_valid, op_code
   );

   modport slave (
      input  start, glyph_row0, glyph_row1, glyph_row2, glyph_row3,
             glyph_row4, glyph_row5, glyph_row6, glyph_row7,
      output busy, done, match_valid, op_code
   );
endinterface

// File: rtl/glyph_operator_matcher_char_rom.sv
// Character ROM holding the operator glyphs (MSB-first rows, 8 bytes per glyph); 1-cycle registered read.
// No flow control: a new address is accepted every cycle; unpopulated addresses read as blank.
module glyph_operator_matcher_char_rom (
   input  logic       i_clk,
   input  logic [9:0] i_addr,
   output logic [7:0] o_q
);
   logic [63:0] w_glyph;
   logic [7:0]  w_byte;
   logic [7:0]  r_q;

   // Row 0 sits in the most significant byte of each glyph word.
   always_comb begin
      w_glyph = 64'h0;
      case (i_addr[9:3])
         7'o53:   w_glyph = 64'h00_18_18_7E_7E_18_18_00;
         7'o55:   w_glyph = 64'h00_00_00_7E_7E_00_00_00;
         7'o52:   w_glyph = 64'h00_66_3C_FF_3C_66_00_00;
         7'o57:   w_glyph = 64'h02_06_0C_18_30_60_40_00;
         7'o46:   w_glyph = 64'h00_7E_7E_00_7E_7E_00_00;
         7'o41:   w_glyph = 64'h0C_18_30_30_30_18_0C_00;
         7'o72:   w_glyph = 64'h30_18_0C_0C_0C_18_30_00;
         7'o67:   w_glyph = 64'h18_3C_66_C3_00_00_00_00;
         7'o70:   w_glyph = 64'h06_0C_18_30_18_0C_06_00;
         7'o71:   w_glyph = 64'h60_30_18_0C_18_30_60_00;
         default: w_glyph = 64'h0;
      endcase
   end

   assign w_byte = w_glyph[{3'd7 - i_addr[2:0], 3'b000} +: 8];

   always_ff @(posedge i_clk) begin
      r_q <= w_byte;
   end

   assign o_q = r_q;
endmodule

// File: rtl/glyph_operator_matcher.sv
// Identifies the operator code of a latched glyph by scanning ROM candidates; 9 cycles per candidate, first match wins.
// start is only accepted in IDLE; requests while busy are dropped, never queued.
module glyph_operator_matcher
   import glyph_operator_matcher_pkg::*;
(
   input logic                    clock,
   input logic                    resetn,
   glyph_operator_matcher_if.slave bus
);
   state_t          r_state, w_state_nxt;
   logic [7:0][7:0] r_rows;
   logic [7:0][7:0] w_rows_in;
   logic [3:0]      r_cand, w_cand_nxt;
   logic [3:0]      r_row, w_row_nxt;
   logic            r_mismatch, w_mismatch_nxt;
   logic            r_match_valid, w_match_valid_nxt;
   logic [7:0]      r_op_code, w_op_code_nxt;
   logic [9:0]      w_addr;
   logic [7:0]      w_q;
   logic [2:0]      w_prev_row;
   logic            w_accept, w_row_eq, w_mis_now, w_last_row, w_last_cand;

   assign w_rows_in = {bus.glyph_row7, bus.glyph_row6, bus.glyph_row5, bus.glyph_row4,
                       bus.glyph_row3, bus.glyph_row2, bus.glyph_row1, bus.glyph_row0};

   assign w_accept = (r_state == ST_IDLE) && bus.start;
   assign w_addr   = op_base(r_cand) + {6'd0, r_row};

   glyph_operator_matcher_char_rom u_char_rom (
      .i_clk  (clock),
      .i_addr (w_addr),
      .o_q    (w_q)
   );

   // q in row slot r belongs to row r-1; the 3-bit wrap maps slot 8 onto row 7.
   assign w_prev_row  = r_row[2:0] - 3'd1;
   assign w_row_eq    = (rev8(w_q) == r_rows[w_prev_row]);
   assign w_mis_now   = r_mismatch | ~w_row_eq;
   assign w_last_row  = (r_row == LAST_ROW);
   assign w_last_cand = (r_cand == LAST_CAND);

   always_comb begin
      w_state_nxt       = r_state;
      w_cand_nxt        = r_cand;
      w_row_nxt         = r_row;
      w_mismatch_nxt    = r_mismatch;
      w_match_valid_nxt = r_match_valid;
      w_op_code_nxt     = r_op_code;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt       = ST_SCAN;
               w_cand_nxt        = 4'd0;
               w_row_nxt         = 4'd0;
               w_mismatch_nxt    = 1'b0;
               w_match_valid_nxt = 1'b0;
               w_op_code_nxt     = 8'd0;
            end
         end
         ST_SCAN: begin
            if (r_row == 4'd0) begin
               w_mismatch_nxt = 1'b0;
               w_row_nxt      = 4'd1;
            end else begin
               w_mismatch_nxt = w_mis_now;
               if (w_last_row) begin
                  if (!w_mis_now) begin
                     w_state_nxt       = ST_DONE;
                     w_match_valid_nxt = 1'b1;
                     w_op_code_nxt     = FIRST_CODE + {4'd0, r_cand};
                  end else if (w_last_cand) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_cand_nxt = r_cand + 4'd1;
                     w_row_nxt  = 4'd0;
                  end
               end else begin
                  w_row_nxt = r_row + 4'd1;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_rows        <= '0;
         r_cand        <= 4'd0;
         r_row         <= 4'd0;
         r_mismatch    <= 1'b0;
         r_match_valid <= 1'b0;
         r_op_code     <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_cand        <= w_cand_nxt;
         r_row         <= w_row_nxt;
         r_mismatch    <= w_mismatch_nxt;
         r_match_valid <= w_match_valid_nxt;
         r_op_code     <= w_op_code_nxt;
         if (w_accept) begin
            r_rows <= w_rows_in;
         end
      end
   end

   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.done        = (r_state == ST_DONE);
   assign bus.match_valid = r_match_valid;
   assign bus.op_code     = r_op_code;
endmodule

// File: tb/tb_glyph_operator_matcher.sv
// Directed bench for the glyph matcher: cycle N is the period ending at edge N, start is sampled at edge 0,
// so the k-th negedge after that edge is observed as cycle k.
module tb_glyph_operator_matcher;
   logic clock;
   logic resetn;
   int   n_checks;
   int   n_fail;

   // Glyphs as seen on the display bus: row r in bits [8r+7:8r], LSB-first pixels.
   localparam logic [63:0] G_PLUS      = 64'h00_18_18_7E_7E_18_18_00;
   localparam logic [63:0] G_GT        = 64'h00_06_0C_18_30_18_0C_06;
   localparam logic [63:0] G_SLASH     = 64'h00_02_06_0C_18_30_60_40;
   localparam logic [63:0] G_SLASH_MSB = 64'h00_40_60_30_18_0C_06_02;
   localparam logic [63:0] G_BLANK     = 64'h0;

   glyph_operator_matcher_if bus_if ();

   glyph_operator_matcher dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic set_rows(input logic [63:0] g);
      bus_if.glyph_row0 = g[7:0];
      bus_if.glyph_row1 = g[15:8];
      bus_if.glyph_row2 = g[23:16];
      bus_if.glyph_row3 = g[31:24];
      bus_if.glyph_row4 = g[39:32];
      bus_if.glyph_row5 = g[47:40];
      bus_if.glyph_row6 = g[55:48];
      bus_if.glyph_row7 = g[63:56];
   endtask

   // Starts a scan at edge 0 and reports the first done cycle (0 if none within the budget),
   // the result in that cycle, and done/result one cycle later.
   task automatic do_scan(input logic [63:0] g, output int done_cyc, output logic mv,
                          output logic [7:0] op, output logic busy1, output logic done_nxt,
                          output logic mv_nxt, output logic [7:0] op_nxt);
      done_cyc = 0;
      mv = 1'b0;
      op = 8'd0;
      busy1 = 1'b0;
      @(negedge clock);
      set_rows(g);
      bus_if.start = 1'b1;
      @(posedge clock);
      for (int n = 1; n <= 200; n++) begin
         @(negedge clock);
         bus_if.start = 1'b0;
         if (n == 1) busy1 = bus_if.busy;
         if (bus_if.done) begin
            done_cyc = n;
            mv = bus_if.match_valid;
            op = bus_if.op_code;
            break;
         end
      end
      @(negedge clock);
      done_nxt = bus_if.done;
      mv_nxt = bus_if.match_valid;
      op_nxt = bus_if.op_code;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus_if.start = 1'b0;
      set_rows(G_BLANK);
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_checks += 4;
      if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
      if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus_if.done); end
      if (bus_if.match_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mv: got %b want 0", bus_if.match_valid); end
      if (bus_if.op_code !== 8'd0) begin n_fail++; $display("FAIL reset_op: got %0d want 0", bus_if.op_code); end
      resetn = 1'b1;
   endtask

   task automatic test_plus();
      int c; logic mv, b1, dn, mvn; logic [7:0] op, opn;
      do_scan(G_PLUS, c, mv, op, b1, dn, mvn, opn);
      n_checks += 7;
      if (b1 !== 1'b1) begin n_fail++; $display("FAIL plus_busy: got %b want 1", b1); end
      if (c !== 10) begin n_fail++; $display("FAIL plus_done_cycle: got %0d want 10", c); end
      if (mv !== 1'b1) begin n_fail++; $display("FAIL plus_mv: got %b want 1", mv); end
      if (op !== 8'd20) begin n_fail++; $display("FAIL plus_op: got %0d want 20", op); end
      if (dn !== 1'b0) begin n_fail++; $display("FAIL plus_done_pulse: got %b want 0", dn); end
      if (mvn !== 1'b1) begin n_fail++; $display("FAIL plus_mv_hold: got %b want 1", mvn); end
      if (opn !== 8'd20) begin n_fail++; $display("FAIL plus_op_hold: got %0d want 20", opn); end
   endtask

   task automatic test_code29();
      int c; logic mv, b1, dn, mvn; logic [7:0] op, opn;
      do_scan(G_GT, c, mv, op, b1, dn, mvn, opn);
      n_checks += 3;
      if (c !== 91) begin n_fail++; $display("FAIL c29_done_cycle: got %0d want 91", c); end
      if (mv !== 1'b1) begin n_fail++; $display("FAIL c29_mv: got %b want 1", mv); end
      if (op !== 8'd29) begin n_fail++; $display("FAIL c29_op: got %0d want 29", op); end
   endtask

   task automatic test_blank();
      int c; logic mv, b1, dn, mvn; logic [7:0] op, opn;
      do_scan(G_BLANK, c, mv, op, b1, dn, mvn, opn);
      n_checks += 3;
      if (c !== 91) begin n_fail++; $display("FAIL blank_done_cycle: got %0d want 91", c); end
      if (mv !== 1'b0) begin n_fail++; $display("FAIL blank_mv: got %b want 0", mv); end
      if (op !== 8'd0) begin n_fail++; $display("FAIL blank_op: got %0d want 0", op); end
   endtask

   task automatic test_orientation();
      int c; logic mv, b1, dn, mvn; logic [7:0] op, opn;
      do_scan(G_SLASH_MSB, c, mv, op, b1, dn, mvn, opn);
      n_checks += 3;
      if (c !== 91) begin n_fail++; $display("FAIL msb_done_cycle: got %0d want 91", c); end
      if (mv !== 1'b0) begin n_fail++; $display("FAIL msb_mv: got %b want 0", mv); end
      if (op !== 8'd0) begin n_fail++; $display("FAIL msb_op: got %0d want 0", op); end
      do_scan(G_SLASH, c, mv, op, b1, dn, mvn, opn);
      n_checks += 3;
      if (c !== 37) begin n_fail++; $display("FAIL lsb_done_cycle: got %0d want 37", c); end
      if (mv !== 1'b1) begin n_fail++; $display("FAIL lsb_mv: got %b want 1", mv); end
      if (op !== 8'd23) begin n_fail++; $display("FAIL lsb_op: got %0d want 23", op); end
   endtask

   task automatic test_start_while_busy();
      int first, cnt; logic mv; logic [7:0] op;
      first = 0; cnt = 0; mv = 1'b0; op = 8'd0;
      @(negedge clock);
      set_rows(G_SLASH);
      bus_if.start = 1'b1;
      @(posedge clock);
      for (int n = 1; n <= 120; n++) begin
         @(negedge clock);
         if (bus_if.done) begin
            cnt++;
            if (first == 0) begin
               first = n; mv = bus_if.match_valid; op = bus_if.op_code;
            end
         end
         bus_if.start = (n == 5 || n == 10);
         if (n == 3) set_rows(G_PLUS);
      end
      bus_if.start = 1'b0;
      n_checks += 4;
      if (cnt !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", cnt); end
      if (first !== 37) begin n_fail++; $display("FAIL busy_done_cycle: got %0d want 37", first); end
      if (mv !== 1'b1) begin n_fail++; $display("FAIL busy_mv: got %b want 1", mv); end
      if (op !== 8'd23) begin n_fail++; $display("FAIL busy_op: got %0d want 23", op); end
   endtask

   task automatic test_reset_mid_scan();
      int c; logic mv, b1, dn, mvn, busy20; logic [7:0] op, opn;
      busy20 = 1'b0;
      @(negedge clock);
      set_rows(G_BLANK);
      bus_if.start = 1'b1;
      @(posedge clock);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         bus_if.start = 1'b0;
         if (n == 20) begin
            busy20 = bus_if.busy;
            resetn = 1'b0;
         end
      end
      @(negedge clock);
      n_checks += 5;
      if (busy20 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", busy20); end
      if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus_if.busy); end
      if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus_if.done); end
      if (bus_if.op_code !== 8'd0) begin n_fail++; $display("FAIL rst_op: got %0d want 0", bus_if.op_code); end
      if (bus_if.match_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mv: got %b want 0", bus_if.match_valid); end
      resetn = 1'b1;
      do_scan(G_PLUS, c, mv, op, b1, dn, mvn, opn);
      n_checks += 3;
      if (c !== 10) begin n_fail++; $display("FAIL rst_rerun_cycle: got %0d want 10", c); end
      if (mv !== 1'b1) begin n_fail++; $display("FAIL rst_rerun_mv: got %b want 1", mv); end
      if (op !== 8'd20) begin n_fail++; $display("FAIL rst_rerun_op: got %0d want 20", op); end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      test_reset();
      test_plus();
      test_code29();
      test_blank();
      test_orientation();
      test_start_while_busy();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
